psx_command_capture: RTL and testbench

- Host-to-device counterpart of the controller reply path. It decodes the command bytes the console sends during each packet, rather than generating reply bytes.
- It taps the psx_device_port command stream (PPB_command / PPB_command_strobe) and validates the address and command bytes.
- It streams the command payload (rumble/actuator and config bytes) into an external dual-port RAM through a registered write port, for the host-side logic to read.
- All state is per-packet and is cleared by PPB_packet_reset.

---
 rtl/psx_command_capture.sv | 122 ++++++++++++
 tb/tb_psx_command_capture.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/psx_command_capture.sv
// psx_command_capture
// Decodes the console-to-controller command bytes of one packet: checks the
// address and command bytes, then streams the payload bytes into an external
// payload RAM through a registered one-cycle write port. Everything restarts
// when PPB_packet_reset is asserted.
module psx_command_capture #(
    parameter logic [7:0] PORT_ADDR   = 8'h01,
    parameter int         MAX_PAYLOAD = 18,
    parameter logic [3:0] CMD_CLASS   = 4'h4
) (
    input  logic       clk,
    input  logic       PPB_packet_reset,
    input  logic [7:0] PPB_command,
    input  logic       PPB_command_strobe,
    output logic       cap_we,
    output logic [4:0] cap_addr,
    output logic [7:0] cap_data,
    output logic [7:0] cmd_code,
    output logic       cmd_valid,
    output logic [4:0] payload_count,
    output logic       overflow
);

    localparam logic [4:0] MAX_CNT = 5'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        ADDR    = 3'd0,
        CMD     = 3'd1,
        PAD     = 3'd2,
        PAYLOAD = 3'd3,
        DROP    = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic       cap_we_q, cap_we_d;
    logic [4:0] cap_addr_q, cap_addr_d;
    logic [7:0] cap_data_q, cap_data_d;
    logic [7:0] cmd_code_q, cmd_code_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic [4:0] payload_count_q, payload_count_d;
    logic       overflow_q, overflow_d;

    // Next-state decode: only a strobed byte moves the packet forward; the write enable is a pulse.
    always_comb begin
        state_d         = state_q;
        cap_we_d        = 1'b0;
        cap_addr_d      = cap_addr_q;
        cap_data_d      = cap_data_q;
        cmd_code_d      = cmd_code_q;
        cmd_valid_d     = cmd_valid_q;
        payload_count_d = payload_count_q;
        overflow_d      = overflow_q;

        if (PPB_command_strobe) begin
            case (state_q)
                ADDR: begin
                    state_d = (PPB_command == PORT_ADDR) ? CMD : DROP;
                end
                CMD: begin
                    cmd_code_d = PPB_command;
                    if (PPB_command[7:4] == CMD_CLASS) begin
                        cmd_valid_d = 1'b1;
                        state_d     = PAD;
                    end else begin
                        state_d = DROP;
                    end
                end
                PAD: begin
                    state_d = PAYLOAD;
                end
                PAYLOAD: begin
                    if (payload_count_q < MAX_CNT) begin
                        cap_we_d        = 1'b1;
                        cap_addr_d      = payload_count_q;
                        cap_data_d      = PPB_command;
                        payload_count_d = payload_count_q + 5'd1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                DROP: begin
                    state_d = DROP;
                end
                default: begin
                    state_d = DROP;
                end
            endcase
        end
    end

    // State and output registers; the packet reset clears everything at once, including a pending write.
    always_ff @(posedge clk or posedge PPB_packet_reset) begin
        if (PPB_packet_reset) begin
            state_q         <= ADDR;
            cap_we_q        <= 1'b0;
            cap_addr_q      <= 5'd0;
            cap_data_q      <= 8'h00;
            cmd_code_q      <= 8'h00;
            cmd_valid_q     <= 1'b0;
            payload_count_q <= 5'd0;
            overflow_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            cap_we_q        <= cap_we_d;
            cap_addr_q      <= cap_addr_d;
            cap_data_q      <= cap_data_d;
            cmd_code_q      <= cmd_code_d;
            cmd_valid_q     <= cmd_valid_d;
            payload_count_q <= payload_count_d;
            overflow_q      <= overflow_d;
        end
    end

    assign cap_we        = cap_we_q;
    assign cap_addr      = cap_addr_q;
    assign cap_data      = cap_data_q;
    assign cmd_code      = cmd_code_q;
    assign cmd_valid     = cmd_valid_q;
    assign payload_count = payload_count_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_psx_command_capture.sv
// Directed testbench for psx_command_capture: each task plays one packet scenario
// and compares outputs and the logged RAM writes against hand-computed values.
module tb_psx_command_capture;

    logic       clk = 1'b0;
    logic       PPB_packet_reset;
    logic [7:0] PPB_command;
    logic       PPB_command_strobe;
    logic       cap_we;
    logic [4:0] cap_addr;
    logic [7:0] cap_data;
    logic [7:0] cmd_code;
    logic       cmd_valid;
    logic [4:0] payload_count;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] pkt[$];
    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];
    int strobe_cyc[$];
    int ovf_cyc = -1;

    psx_command_capture dut (
        .clk                (clk),
        .PPB_packet_reset   (PPB_packet_reset),
        .PPB_command        (PPB_command),
        .PPB_command_strobe (PPB_command_strobe),
        .cap_we             (cap_we),
        .cap_addr           (cap_addr),
        .cap_data           (cap_data),
        .cmd_code           (cmd_code),
        .cmd_valid          (cmd_valid),
        .payload_count      (payload_count),
        .overflow           (overflow)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Cycle counter used to timestamp strobes and writes.
    always @(posedge clk) cyc <= cyc + 1;

    // Log every RAM write and the first cycle overflow is seen, sampled mid-cycle.
    always @(negedge clk) begin
        if (cap_we === 1'b1) begin
            wr_addr.push_back(int'(cap_addr));
            wr_data.push_back(int'(cap_data));
            wr_cyc.push_back(cyc);
        end
        if (overflow === 1'b1 && ovf_cyc < 0) ovf_cyc = cyc;
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        strobe_cyc.delete();
        ovf_cyc = -1;
    endtask

    // Drive the bytes in pkt, one strobe per byte; gap inserts an idle cycle between bytes.
    task automatic send_packet(input bit gap);
        for (int i = 0; i < pkt.size(); i++) begin
            @(posedge clk); #2;
            PPB_command        = pkt[i];
            PPB_command_strobe = 1'b1;
            strobe_cyc.push_back(cyc);
            if (gap) begin
                @(posedge clk); #2;
                PPB_command_strobe = 1'b0;
            end
        end
        @(posedge clk); #2;
        PPB_command_strobe = 1'b0;
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2;
        PPB_packet_reset = 1'b1;
        @(posedge clk); #2;
        PPB_packet_reset = 1'b0;
        clear_log();
    endtask

    task automatic test_reset();
        PPB_packet_reset   = 1'b1;
        PPB_command        = 8'h01;
        PPB_command_strobe = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (cap_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_cap_we got=%b exp=0", cap_we); end
        checks++; if (cap_addr !== 5'd0) begin errors++; $display("[TB] FAIL reset_cap_addr got=%0d exp=0", cap_addr); end
        checks++; if (cap_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_cap_data got=%h exp=00", cap_data); end
        checks++; if (cmd_code !== 8'h00) begin errors++; $display("[TB] FAIL reset_cmd_code got=%h exp=00", cmd_code); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_cmd_valid got=%b exp=0", cmd_valid); end
        checks++; if (payload_count !== 5'd0) begin errors++; $display("[TB] FAIL reset_count got=%0d exp=0", payload_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got=%b exp=0", overflow); end
        PPB_command_strobe = 1'b0;
        PPB_command        = 8'h00;
        PPB_packet_reset   = 1'b0;
        clear_log();
    endtask

    task automatic test_nominal();
        pulse_reset();
        pkt = {8'h01, 8'h42, 8'h00, 8'hFF, 8'h40};
        send_packet(1'b1);
        checks++; if (cmd_code !== 8'h42) begin errors++; $display("[TB] FAIL nom_cmd_code got=%h exp=42", cmd_code); end
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("[TB] FAIL nom_cmd_valid got=%b exp=1", cmd_valid); end
        checks++; if (payload_count !== 5'd2) begin errors++; $display("[TB] FAIL nom_count got=%0d exp=2", payload_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL nom_overflow got=%b exp=0", overflow); end
        checks++; if (wr_addr.size() != 2) begin errors++; $display("[TB] FAIL nom_writes got=%0d exp=2", wr_addr.size()); end
        if (wr_addr.size() == 2) begin
            checks++; if (wr_addr[0] != 0 || wr_data[0] != 'hFF) begin errors++; $display("[TB] FAIL nom_wr0 got=(%0d,%h) exp=(0,ff)", wr_addr[0], wr_data[0]); end
            checks++; if (wr_addr[1] != 1 || wr_data[1] != 'h40) begin errors++; $display("[TB] FAIL nom_wr1 got=(%0d,%h) exp=(1,40)", wr_addr[1], wr_data[1]); end
            checks++; if (wr_cyc[0] != strobe_cyc[3] + 1) begin errors++; $display("[TB] FAIL nom_lat0 got=%0d exp=%0d", wr_cyc[0], strobe_cyc[3] + 1); end
            checks++; if (wr_cyc[1] != strobe_cyc[4] + 1) begin errors++; $display("[TB] FAIL nom_lat1 got=%0d exp=%0d", wr_cyc[1], strobe_cyc[4] + 1); end
        end
        checks++; if (cap_we !== 1'b0 || cap_addr !== 5'd1 || cap_data !== 8'h40) begin errors++; $display("[TB] FAIL nom_hold got=(%b,%0d,%h) exp=(0,1,40)", cap_we, cap_addr, cap_data); end
    endtask

    task automatic test_wrong_address();
        pulse_reset();
        pkt = {8'h02, 8'h42, 8'h00, 8'h11};
        send_packet(1'b1);
        checks++; if (wr_addr.size() != 0) begin errors++; $display("[TB] FAIL waddr_writes got=%0d exp=0", wr_addr.size()); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL waddr_cmd_valid got=%b exp=0", cmd_valid); end
        checks++; if (cmd_code !== 8'h00) begin errors++; $display("[TB] FAIL waddr_cmd_code got=%h exp=00", cmd_code); end
        checks++; if (payload_count !== 5'd0) begin errors++; $display("[TB] FAIL waddr_count got=%0d exp=0", payload_count); end
    endtask

    task automatic test_bad_command();
        pulse_reset();
        pkt = {8'h01, 8'h30, 8'h00, 8'hAA, 8'hBB};
        send_packet(1'b0);
        checks++; if (cmd_code !== 8'h30) begin errors++; $display("[TB] FAIL badcmd_cmd_code got=%h exp=30", cmd_code); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL badcmd_cmd_valid got=%b exp=0", cmd_valid); end
        checks++; if (wr_addr.size() != 0) begin errors++; $display("[TB] FAIL badcmd_writes got=%0d exp=0", wr_addr.size()); end
        checks++; if (payload_count !== 5'd0) begin errors++; $display("[TB] FAIL badcmd_count got=%0d exp=0", payload_count); end
    endtask

    task automatic test_overflow();
        int bad;
        pulse_reset();
        pkt = {8'h01, 8'h43, 8'h00};
        for (int i = 0; i < 20; i++) pkt.push_back(8'(i));
        send_packet(1'b0);
        checks++; if (wr_addr.size() != 18) begin errors++; $display("[TB] FAIL ovf_writes got=%0d exp=18", wr_addr.size()); end
        if (wr_addr.size() == 18) begin
            bad = 0;
            for (int i = 0; i < 18; i++)
                if (wr_addr[i] != i || wr_data[i] != i || wr_cyc[i] != strobe_cyc[3 + i] + 1) bad++;
            checks++; if (bad != 0) begin errors++; $display("[TB] FAIL ovf_write_seq got=%0d bad entries exp=0", bad); end
        end
        checks++; if (payload_count !== 5'd18) begin errors++; $display("[TB] FAIL ovf_count got=%0d exp=18", payload_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got=%b exp=1", overflow); end
        checks++; if (ovf_cyc != strobe_cyc[21] + 1) begin errors++; $display("[TB] FAIL ovf_timing got=%0d exp=%0d", ovf_cyc, strobe_cyc[21] + 1); end
        checks++; if (cap_addr !== 5'd17 || cap_data !== 8'h11) begin errors++; $display("[TB] FAIL ovf_hold got=(%0d,%h) exp=(17,11)", cap_addr, cap_data); end
    endtask

    task automatic test_reset_mid_write();
        pulse_reset();
        pkt = {8'h01, 8'h42, 8'h00, 8'h11, 8'h22};
        for (int i = 0; i < pkt.size(); i++) begin
            @(posedge clk); #2;
            PPB_command        = pkt[i];
            PPB_command_strobe = 1'b1;
            @(posedge clk); #2;
            PPB_command_strobe = 1'b0;
        end
        checks++; if (payload_count !== 5'd2) begin errors++; $display("[TB] FAIL midrst_pre_count got=%0d exp=2", payload_count); end
        @(posedge clk); #2;
        PPB_command        = 8'h33;
        PPB_command_strobe = 1'b1;
        #1;
        PPB_packet_reset = 1'b1;
        #1;
        checks++; if (cap_we !== 1'b0 || cap_addr !== 5'd0 || cap_data !== 8'h00) begin errors++; $display("[TB] FAIL midrst_port got=(%b,%0d,%h) exp=(0,0,00)", cap_we, cap_addr, cap_data); end
        checks++; if (cmd_code !== 8'h00 || cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_cmd got=(%h,%b) exp=(00,0)", cmd_code, cmd_valid); end
        checks++; if (payload_count !== 5'd0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL midrst_count got=(%0d,%b) exp=(0,0)", payload_count, overflow); end
        @(posedge clk); #2;
        PPB_command_strobe = 1'b0;
        PPB_packet_reset   = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (wr_data.size() != 2) begin errors++; $display("[TB] FAIL midrst_writes got=%0d exp=2", wr_data.size()); end
        clear_log();
        pkt = {8'h01, 8'h42, 8'h00, 8'h5A};
        send_packet(1'b0);
        checks++; if (wr_addr.size() != 1) begin errors++; $display("[TB] FAIL midrst_next_writes got=%0d exp=1", wr_addr.size()); end
        if (wr_addr.size() == 1) begin
            checks++; if (wr_addr[0] != 0 || wr_data[0] != 'h5A) begin errors++; $display("[TB] FAIL midrst_next_wr got=(%0d,%h) exp=(0,5a)", wr_addr[0], wr_data[0]); end
        end
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        pkt = {8'h01, 8'h4D, 8'h00, 8'h01, 8'h02, 8'h03};
        send_packet(1'b0);
        checks++; if (wr_addr.size() != 3) begin errors++; $display("[TB] FAIL b2b_writes got=%0d exp=3", wr_addr.size()); end
        if (wr_addr.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_addr[i] != i || wr_data[i] != i + 1 || wr_cyc[i] != strobe_cyc[3 + i] + 1) begin
                    errors++;
                    $display("[TB] FAIL b2b_wr%0d got=(%0d,%h,c%0d) exp=(%0d,%h,c%0d)", i, wr_addr[i], wr_data[i], wr_cyc[i], i, i + 1, strobe_cyc[3 + i] + 1);
                end
            end
            checks++; if (wr_cyc[2] != wr_cyc[0] + 2) begin errors++; $display("[TB] FAIL b2b_consecutive got=%0d exp=%0d", wr_cyc[2], wr_cyc[0] + 2); end
        end
        checks++; if (cmd_code !== 8'h4D || payload_count !== 5'd3) begin errors++; $display("[TB] FAIL b2b_state got=(%h,%0d) exp=(4d,3)", cmd_code, payload_count); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_nominal();
        test_wrong_address();
        test_bad_command();
        test_overflow();
        test_reset_mid_write();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
